// File: rtl/kvadd2_control_s_axi.sv
// AXI4-Lite control register file for kvadd2: turns host writes into ap_start and the
// scalar kernel arguments, tracks busy/done from ap_done, and raises a level interrupt.
module kvadd2_control_s_axi #(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [1:0]                      s_axi_bresp,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            ap_start,
  input  logic                            ap_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
  output logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant,
  output logic                            interrupt
);

  localparam logic [5:0] A_CTRL    = 6'h00;
  localparam logic [5:0] A_GIE     = 6'h04;
  localparam logic [5:0] A_IER     = 6'h08;
  localparam logic [5:0] A_ISR     = 6'h0C;
  localparam logic [5:0] A_CONST   = 6'h10;
  localparam logic [5:0] A_XFER    = 6'h18;
  localparam logic [5:0] A_ADDR_LO = 6'h20;
  localparam logic [5:0] A_ADDR_HI = 6'h24;

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_e;
  typedef enum logic {RDIDLE, RDDATA} rstate_e;

  wstate_e     wstate_q, wstate_d;
  rstate_e     rstate_q, rstate_d;
  logic [5:0]  waddr_q;
  logic [31:0] rdata_q, rd_val;
  logic        busy_q, busy_d, done_q, done_d, auto_q, auto_d;
  logic        gie_q, gie_d, ier_q, ier_d, isr_q, isr_d;
  logic        start_q, start_d, int_q;
  logic [31:0] const_q, const_d, xfer_q, xfer_d, alo_q, alo_d, ahi_q, ahi_d;
  logic        aw_hs, w_hs, ar_hs, done_evt, start_wr, isr_tog, done_rd;
  logic        unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    merge = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) merge[b*8 +: 8] = new_v[b*8 +: 8];
  endfunction

  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  always_comb begin
    wstate_d      = wstate_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wstate_q)
      WRIDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) wstate_d = WRDATA;
      end
      WRDATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) wstate_d = WRRESP;
      end
      WRRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wstate_d = WRIDLE;
      end
      default: wstate_d = WRIDLE;
    endcase
  end

  always_comb begin
    rstate_d      = rstate_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (rstate_q)
      RDIDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) rstate_d = RDDATA;
      end
      RDDATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) rstate_d = RDIDLE;
      end
      default: rstate_d = RDIDLE;
    endcase
  end

  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready;
  assign done_evt = ap_done & busy_q;
  assign start_wr = w_hs && waddr_q == A_CTRL && s_axi_wstrb[0] && s_axi_wdata[0] && !busy_q;
  assign isr_tog  = w_hs && waddr_q == A_ISR && s_axi_wstrb[0] && s_axi_wdata[0];
  // A done arriving with the status read is reported by that read and survives it.
  assign done_rd  = done_q | done_evt;

  always_comb begin
    busy_d  = busy_q;
    auto_d  = auto_q;
    gie_d   = gie_q;
    ier_d   = ier_q;
    const_d = const_q;
    xfer_d  = xfer_q;
    alo_d   = alo_q;
    ahi_d   = ahi_q;
    if (w_hs) begin
      case (waddr_q)
        A_CTRL:    if (s_axi_wstrb[0]) auto_d = s_axi_wdata[7];
        A_GIE:     if (s_axi_wstrb[0]) gie_d = s_axi_wdata[0];
        A_IER:     if (s_axi_wstrb[0]) ier_d = s_axi_wdata[0];
        A_CONST:   const_d = merge(const_q, s_axi_wdata, s_axi_wstrb);
        A_XFER:    xfer_d  = merge(xfer_q, s_axi_wdata, s_axi_wstrb);
        A_ADDR_LO: alo_d   = merge(alo_q, s_axi_wdata, s_axi_wstrb);
        A_ADDR_HI: ahi_d   = merge(ahi_q, s_axi_wdata, s_axi_wstrb);
        default: ;
      endcase
    end
    if (start_wr) busy_d = 1'b1;
    if (done_evt) busy_d = auto_q;
    start_d = start_wr | (done_evt & auto_q);
    done_d  = (ar_hs && s_axi_araddr[5:0] == A_CTRL) ? 1'b0 : done_q;
    if (done_evt) done_d = 1'b1;
    isr_d = isr_q ^ isr_tog;
    if (done_evt && ier_q) isr_d = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (s_axi_araddr[5:0])
      A_CTRL:    rd_val = {24'b0, auto_q, 3'b0, done_rd, ~busy_q, done_rd, busy_q};
      A_GIE:     rd_val = {31'b0, gie_q};
      A_IER:     rd_val = {31'b0, ier_q};
      A_ISR:     rd_val = {31'b0, isr_q};
      A_CONST:   rd_val = const_q;
      A_XFER:    rd_val = xfer_q;
      A_ADDR_LO: rd_val = alo_q;
      A_ADDR_HI: rd_val = ahi_q;
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wstate_q <= WRIDLE;
      rstate_q <= RDIDLE;
      waddr_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      auto_q   <= 1'b0;
      gie_q    <= 1'b0;
      ier_q    <= 1'b0;
      isr_q    <= 1'b0;
      start_q  <= 1'b0;
      int_q    <= 1'b0;
      const_q  <= '0;
      xfer_q   <= '0;
      alo_q    <= '0;
      ahi_q    <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      if (aw_hs) waddr_q <= s_axi_awaddr[5:0];
      if (ar_hs) rdata_q <= rd_val;
      busy_q   <= busy_d;
      done_q   <= done_d;
      auto_q   <= auto_d;
      gie_q    <= gie_d;
      ier_q    <= ier_d;
      isr_q    <= isr_d;
      start_q  <= start_d;
      int_q    <= gie_q & ier_q & isr_q;
      const_q  <= const_d;
      xfer_q   <= xfer_d;
      alo_q    <= alo_d;
      ahi_q    <= ahi_d;
    end
  end

  assign s_axi_bresp             = 2'b00;
  assign s_axi_rresp             = 2'b00;
  assign s_axi_rdata             = rdata_q;
  assign ap_start                = start_q;
  assign interrupt               = int_q;
  assign ctrl_constant           = C_ADDER_BIT_WIDTH'(const_q);
  assign ctrl_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(xfer_q);
  assign ctrl_addr_offset        = C_M_AXI_ADDR_WIDTH'({ahi_q, alo_q});

endmodule

// File: tb/tb_kvadd2_control_s_axi.sv
// Self-checking bench for kvadd2_control_s_axi: vector table, random register traffic
// against a register-map model, and directed start/done/interrupt/reset sequences.
module tb_kvadd2_control_s_axi;
  logic        aclk = 1'b0, areset_n = 1'b0;
  logic        s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
  logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [31:0] s_axi_wdata = '0, s_axi_rdata;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready = 0;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        ap_start, ap_done = 0, interrupt;
  logic [63:0] ctrl_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes, ctrl_constant;

  kvadd2_control_s_axi dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .ap_start(ap_start),
    .ap_done(ap_done), .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes), .ctrl_constant(ctrl_constant),
    .interrupt(interrupt)
  );

  always #5 aclk = ~aclk;

  int tests = 0, fails = 0, start_cnt = 0, exp_starts = 0, rd_wait = 0;
  always @(negedge aclk) if (ap_start) start_cnt <= start_cnt + 1;

  // Register-map model
  logic [31:0] m_const, m_xfer, m_alo, m_ahi;
  bit m_gie, m_ier, m_isr, m_busy, m_done, m_auto;

  typedef struct { logic [11:0] addr; logic [31:0] data; logic [3:0] strb; logic [31:0] exp; } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic m_reset();
    {m_const, m_xfer, m_alo, m_ahi} = '0;
    {m_gie, m_ier, m_isr, m_busy, m_done, m_auto} = '0;
  endtask

  function automatic logic [31:0] m_bytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[5:0])
      6'h00: if (s[0]) begin
        m_auto = d[7];
        if (d[0] && !m_busy) begin m_busy = 1; exp_starts++; end
      end
      6'h04: if (s[0]) m_gie = d[0];
      6'h08: if (s[0]) m_ier = d[0];
      6'h0C: if (s[0] && d[0]) m_isr = !m_isr;
      6'h10: m_const = m_bytes(m_const, d, s);
      6'h18: m_xfer  = m_bytes(m_xfer, d, s);
      6'h20: m_alo   = m_bytes(m_alo, d, s);
      6'h24: m_ahi   = m_bytes(m_ahi, d, s);
      default: ;
    endcase
  endtask

  task automatic m_done_pulse();
    if (m_busy) begin
      m_busy = m_auto;
      m_done = 1;
      if (m_ier) m_isr = 1;
      if (m_auto) exp_starts++;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a[5:0])
      6'h00: return (32'(m_auto) << 7) | (32'(m_done) << 3) | (32'(!m_busy) << 2) |
                    (32'(m_done) << 1) | 32'(m_busy);
      6'h04: return 32'(m_gie);
      6'h08: return 32'(m_ier);
      6'h0C: return 32'(m_isr);
      6'h10: return m_const;
      6'h18: return m_xfer;
      6'h20: return m_alo;
      6'h24: return m_ahi;
      default: return 32'h0;
    endcase
  endfunction

  // Bus phase tasks: entered at a negedge, return at the negedge after their handshake.
  task automatic aw_phase(input logic [11:0] a);
    int n = 0;
    s_axi_awvalid = 1; s_axi_awaddr = a;
    while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check("awready_timeout", 0, 1);
    @(negedge aclk); s_axi_awvalid = 0;
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_wvalid = 1; s_axi_wdata = d; s_axi_wstrb = s;
    while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check("wready_timeout", 0, 1);
    @(negedge aclk); s_axi_wvalid = 0;
  endtask

  task automatic b_phase();
    int n = 0;
    s_axi_bready = 1;
    while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check("bvalid_timeout", 0, 1);
    @(negedge aclk); s_axi_bready = 0;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge aclk);
    aw_phase(a); w_phase(d, s); b_phase();
    m_write(a, d, s);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge aclk);
    s_axi_arvalid = 1; s_axi_araddr = a;
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check("arready_timeout", 0, 1);
    @(negedge aclk); s_axi_arvalid = 0; s_axi_rready = 1;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) check("rvalid_timeout", 0, 1);
    rd_wait = n;
    d = s_axi_rdata;
    @(negedge aclk); s_axi_rready = 0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a);
    logic [31:0] d;
    axi_read(a, d);
    check(name, d, m_read(a));
    if (a[5:0] == 6'h00) m_done = 0;
  endtask

  // Returns ap_start as seen in the cycle after the done pulse.
  task automatic pulse_done(output logic st);
    @(negedge aclk); ap_done = 1;
    @(negedge aclk); ap_done = 0; st = ap_start;
    m_done_pulse();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        st;
    logic [11:0] raddrs[8];
    int          s0;
    bit          bv_seen;
    raddrs = '{12'h004, 12'h008, 12'h010, 12'h018, 12'h020, 12'h024, 12'h028, 12'h030};
    vecs[0] = '{12'h010, 32'hAABBCCDD, 4'b0101, 32'h00BB00DD};
    vecs[1] = '{12'h020, 32'hDEAD0000, 4'b1111, 32'hDEAD0000};
    vecs[2] = '{12'h024, 32'h00000001, 4'b1111, 32'h00000001};
    vecs[3] = '{12'h018, 32'h00001000, 4'b1111, 32'h00001000};
    vecs[4] = '{12'h010, 32'h00000005, 4'b1111, 32'h00000005};
    vecs[5] = '{12'h03C, 32'h12345678, 4'b1111, 32'h00000000};
    vecs[6] = '{12'h014, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
    m_reset();

    // Reset
    repeat (4) @(negedge aclk);
    check("rst_ap_start", ap_start, 0);
    check("rst_interrupt", interrupt, 0);
    areset_n = 1;
    @(negedge aclk);
    check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b101);
    check("rst_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check("rst_rdata", s_axi_rdata, 0);
    axi_read(12'h000, d);
    check("rst_ctrl", d, 32'h4);
    check("rd_latency", rd_wait, 0);
    axi_read(12'h010, d);
    check("rst_const", d, 32'h0);

    // Vector table
    foreach (vecs[i]) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      axi_read(vecs[i].addr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end
    check("ctrl_addr_offset", ctrl_addr_offset, 64'h1_DEAD0000);
    check("ctrl_xfer", ctrl_xfer_size_in_bytes, 32'h1000);
    check("ctrl_constant", ctrl_constant, 32'h5);

    // Random register traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [11:0] a;
      a = raddrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 2) != 0) axi_write(a, $urandom, 4'($urandom_range(0, 15)));
      else rd_chk($sformatf("rand_rd_%0h", a), a);
    end
    check("rand_addr_out", ctrl_addr_offset, {m_ahi, m_alo});
    check("rand_const_out", ctrl_constant, m_const);
    axi_write(12'h004, 0, 4'hF);
    axi_write(12'h008, 0, 4'hF);

    // Start / done
    s0 = start_cnt;
    axi_write(12'h000, 1, 4'hF);
    repeat (2) @(negedge aclk);
    check("start_one_pulse", start_cnt - s0, 1);
    axi_read(12'h000, d);
    check("busy_ctrl", d, 32'h1);
    axi_write(12'h000, 1, 4'hF);
    repeat (2) @(negedge aclk);
    check("start_while_busy", start_cnt - s0, 1);
    pulse_done(st);
    axi_read(12'h000, d);
    check("done_ctrl", d, 32'hE);
    m_done = 0;
    axi_read(12'h000, d);
    check("done_cleared", d, 32'h4);

    // Interrupt
    axi_write(12'h004, 1, 4'hF);
    axi_write(12'h008, 1, 4'hF);
    axi_write(12'h000, 1, 4'hF);
    pulse_done(st);
    check("int_lag", interrupt, 0);
    @(negedge aclk);
    check("int_rise", interrupt, 1);
    rd_chk("isr_set", 12'h00C);
    axi_write(12'h00C, 1, 4'hF);
    check("int_clear", interrupt, 0);
    rd_chk("isr_cleared", 12'h00C);
    rd_chk("ctrl_after_int", 12'h000);

    // Done set coincident with the status read
    axi_write(12'h000, 1, 4'hF);
    @(negedge aclk);
    s_axi_arvalid = 1; s_axi_araddr = 12'h000; ap_done = 1;
    @(negedge aclk);
    s_axi_arvalid = 0; ap_done = 0; s_axi_rready = 1;
    check("rd_done_race_valid", s_axi_rvalid, 1);
    check("rd_done_race_data", s_axi_rdata, 32'hB);
    m_done_pulse();
    @(negedge aclk); s_axi_rready = 0;
    rd_chk("done_survives_read", 12'h000);

    // ISR toggle write coincident with a done-driven set
    axi_write(12'h00C, 1, 4'hF);
    axi_write(12'h000, 1, 4'hF);
    @(negedge aclk);
    aw_phase(12'h00C);
    s_axi_wvalid = 1; s_axi_wdata = 1; s_axi_wstrb = 4'hF; ap_done = 1;
    @(negedge aclk);
    s_axi_wvalid = 0; ap_done = 0;
    m_done_pulse();
    b_phase();
    rd_chk("isr_set_wins", 12'h00C);
    check("isr_set_wins_int", interrupt, 1);
    axi_write(12'h00C, 1, 4'hF);
    axi_write(12'h004, 0, 4'hF);
    axi_write(12'h008, 0, 4'hF);
    rd_chk("ctrl_before_auto", 12'h000);

    // Auto-restart
    s0 = start_cnt - exp_starts;
    axi_write(12'h000, 32'h81, 4'hF);
    for (int i = 0; i < 3; i++) begin
      pulse_done(st);
      check($sformatf("auto_restart_%0d", i), st, 1);
      if (i == 0) rd_chk("auto_ctrl", 12'h000);
    end
    axi_write(12'h000, 32'h00, 4'hF);
    pulse_done(st);
    check("auto_off_no_start", st, 0);
    rd_chk("auto_off_ctrl", 12'h000);
    rd_chk("auto_off_idle", 12'h000);
    repeat (2) @(negedge aclk);
    check("start_total", start_cnt - s0, exp_starts);

    // Reset during WRDATA
    axi_write(12'h010, 32'h55, 4'hF);
    axi_write(12'h000, 1, 4'hF);
    repeat (2) @(negedge aclk);
    s0 = start_cnt;
    @(negedge aclk);
    aw_phase(12'h010);
    s_axi_wvalid = 1; s_axi_wdata = 32'hFFFFFFFF; s_axi_wstrb = 4'hF; areset_n = 0;
    bv_seen = 0;
    @(negedge aclk);
    s_axi_wvalid = 0;
    repeat (2) begin @(negedge aclk); bv_seen |= s_axi_bvalid; end
    areset_n = 1;
    repeat (3) begin @(negedge aclk); bv_seen |= s_axi_bvalid; end
    check("rst_no_bvalid", bv_seen, 0);
    check("rst_no_start", start_cnt - s0, 0);
    m_reset();
    axi_read(12'h000, d);
    check("rst2_ctrl", d, 32'h4);
    foreach (raddrs[i]) rd_chk($sformatf("rst2_reg_%0h", raddrs[i]), raddrs[i]);
    rd_chk("rst2_isr", 12'h00C);
    check("rst2_outputs", {ctrl_addr_offset, ctrl_constant}, 96'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
